// File: rtl/vram_port_pkg.sv
// Shared definitions for the VRAM CPU port: register indices, FSM states
// and STATUS register bit positions.
package vram_port_pkg;

    // CPU register select values
    localparam logic [1:0] REG_ADDR   = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // STATUS register bit positions
    localparam int STATUS_BUSY = 0;
    localparam int STATUS_FULL = 1;
    localparam int STATUS_OVF  = 2;

    // Pointer step when CTRL bit0 selects row stride
    localparam int ROW_STRIDE = 32;

    // Memory-side sequencer states
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_RD_REQ  = 2'd2,
        S_RD_WAIT = 2'd3
    } state_t;

endpackage

// File: rtl/vram_wfifo.sv
// Synchronous write queue for the VRAM port. Entries are {address, data}.
// Depth must be a power of two; pointers carry one extra wrap bit so that
// full and empty can be told apart.
module vram_wfifo #(
    parameter int P_depth = 4,
    parameter int P_width = 24
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [P_width-1:0] wr_data,
    input  logic               pop,
    output logic [P_width-1:0] rd_data,
    output logic               full,
    output logic               empty
);

    localparam int AW = (P_depth > 1) ? $clog2(P_depth) : 1;

    logic [P_width-1:0] slots [P_depth];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;

    // Storage write; only accepted when there is room
    always_ff @(posedge clock) begin
        if (push && !full) begin
            slots[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Read/write pointer advance
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign rd_data = slots[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/vram_port.sv
// CPU-to-video-memory access port. The CPU sees four byte registers
// (ADDR, DATA, CTRL, STATUS); DATA writes are queued and drained to the
// shared memory port whenever the video fetcher grants a free cycle.
// Optional feature macro: VRAM_READBACK_EN enables DATA reads through a
// prefetching read buffer. Without it DATA reads return 0 and the memory
// read request is never raised.
module vram_port
    import vram_port_pkg::*;
#(
    parameter int P_fifo_depth = 4,
    parameter int P_addr_bits  = 16
) (
    input  logic                   I_clock,
    input  logic                   I_reset,
    input  logic                   I_cpu_strobe,
    input  logic                   I_cpu_rdwr,
    input  logic [1:0]             I_cpu_addr,
    input  logic [7:0]             I_cpu_wr_data,
    output logic [7:0]             O_cpu_rd_data,
    output logic [P_addr_bits-1:0] O_mem_addr,
    output logic [7:0]             O_mem_wr_data,
    output logic                   O_mem_wren,
    output logic                   O_mem_rden,
    input  logic                   I_mem_grant,
    input  logic [7:0]             I_mem_rd_data
);

    localparam int EW = P_addr_bits + 8;

    state_t                 state;
    logic [P_addr_bits-1:0] pointer;
    logic [7:0]             addr_hi;
    logic                   toggle;
    logic                   ctrl_stride;
    logic                   ovf;
    logic                   prefetch_pending;
    logic [7:0]             rd_buf;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [EW-1:0]          fifo_dout;

    logic                   addr_wr;
    logic                   data_wr;
    logic                   ctrl_wr;
    logic                   status_rd;
    logic                   cpu_rd;
    logic                   ovf_set;
    logic                   prefetch_take;
    logic                   busy;
    logic [P_addr_bits-1:0] step;
    logic [15:0]            addr_word;
    logic [7:0]             rd_mux;

    assign addr_wr   = I_cpu_strobe && !I_cpu_rdwr && (I_cpu_addr == REG_ADDR);
    assign data_wr   = I_cpu_strobe && !I_cpu_rdwr && (I_cpu_addr == REG_DATA);
    assign ctrl_wr   = I_cpu_strobe && !I_cpu_rdwr && (I_cpu_addr == REG_CTRL);
    assign cpu_rd    = I_cpu_strobe && I_cpu_rdwr;
    assign status_rd = cpu_rd && (I_cpu_addr == REG_STATUS);

    // A write into a full queue is dropped and latched as overflow
    assign fifo_push = data_wr && !fifo_full;
    assign ovf_set   = data_wr && fifo_full;
    assign fifo_pop  = (state == S_WRITE) && I_mem_grant;

    assign step      = ctrl_stride ? P_addr_bits'(ROW_STRIDE) : P_addr_bits'(1);
    assign addr_word = {addr_hi, I_cpu_wr_data};

    // Queued writes always win over a pending prefetch
    assign prefetch_take = (state == S_IDLE) && fifo_empty && prefetch_pending;
    assign busy          = !fifo_empty || prefetch_pending || (state != S_IDLE);

`ifdef VRAM_READBACK_EN
    logic data_rd;
    assign data_rd = cpu_rd && (I_cpu_addr == REG_DATA);
`else
    logic unused_rd_buf;
    assign unused_rd_buf = ^rd_buf;
`endif

    // CPU register read multiplexer
    always_comb begin
        rd_mux = 8'h00;
        case (I_cpu_addr)
            REG_CTRL: rd_mux = {7'b0, ctrl_stride};
            REG_STATUS: begin
                rd_mux[STATUS_BUSY] = busy;
                rd_mux[STATUS_FULL] = fifo_full;
                rd_mux[STATUS_OVF]  = ovf;
            end
`ifdef VRAM_READBACK_EN
            REG_DATA: rd_mux = rd_buf;
`endif
            default: rd_mux = 8'h00;
        endcase
    end

    vram_wfifo #(
        .P_depth (P_fifo_depth),
        .P_width (EW)
    ) u_wfifo (
        .clock   (I_clock),
        .reset   (I_reset),
        .push    (fifo_push),
        .wr_data ({pointer, I_cpu_wr_data}),
        .pop     (fifo_pop),
        .rd_data (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // CPU register file: pointer, address toggle, control, overflow, read data
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            pointer          <= '0;
            addr_hi          <= 8'h00;
            toggle           <= 1'b0;
            ctrl_stride      <= 1'b0;
            ovf              <= 1'b0;
            prefetch_pending <= 1'b0;
            O_cpu_rd_data    <= 8'h00;
        end else begin
            if (prefetch_take) begin
                prefetch_pending <= 1'b0;
            end
            if (addr_wr) begin
                if (!toggle) begin
                    addr_hi <= I_cpu_wr_data;
                    toggle  <= 1'b1;
                end else begin
                    pointer <= P_addr_bits'(addr_word);
                    toggle  <= 1'b0;
`ifdef VRAM_READBACK_EN
                    prefetch_pending <= 1'b1;
`endif
                end
            end
            if (ctrl_wr) begin
                ctrl_stride <= I_cpu_wr_data[0];
            end
            if (fifo_push) begin
                pointer <= pointer + step;
            end
`ifdef VRAM_READBACK_EN
            if (data_rd) begin
                pointer          <= pointer + step;
                prefetch_pending <= 1'b1;
            end
`endif
            if (status_rd) begin
                toggle <= 1'b0;
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (status_rd) begin
                ovf <= 1'b0;
            end
            if (cpu_rd) begin
                O_cpu_rd_data <= rd_mux;
            end
        end
    end

    // Memory-side sequencer with registered request outputs
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            state         <= S_IDLE;
            O_mem_addr    <= '0;
            O_mem_wr_data <= 8'h00;
            O_mem_wren    <= 1'b0;
            O_mem_rden    <= 1'b0;
            rd_buf        <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state         <= S_WRITE;
                        O_mem_wren    <= 1'b1;
                        O_mem_addr    <= fifo_dout[EW-1:8];
                        O_mem_wr_data <= fifo_dout[7:0];
                    end
`ifdef VRAM_READBACK_EN
                    else if (prefetch_pending) begin
                        state      <= S_RD_REQ;
                        O_mem_rden <= 1'b1;
                        O_mem_addr <= pointer;
                    end
`endif
                end
                S_WRITE: begin
                    if (I_mem_grant) begin
                        O_mem_wren <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                S_RD_REQ: begin
                    if (I_mem_grant) begin
                        O_mem_rden <= 1'b0;
                        state      <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    rd_buf <= I_mem_rd_data;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
